// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the program loader: bus widths,
// default frame marker and the loader FSM state type.
// LOADER_CHECKSUM_EN adds the CHECK state to the state type.
package arch_defs_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;

  localparam logic [DATA_WIDTH-1:0] LOADER_SYNC_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } loader_state_t;

  // States in which the inter-byte timeout is armed (inside a frame).
  function automatic logic in_frame(loader_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts consecutive enabled cycles without a clear
// and flags expiry on the CYCLES-th such cycle, so the owner can act on
// the same edge that completes the count.
module loader_timeout #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !clear && (cnt == CW'(CYCLES - 1));

  // Idle-cycle counter; any transfer or leaving the frame restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (clear || !enable) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/ADDR_HI/ADDR_LO/LEN/data frames,
// writes data bytes to consecutive addresses and releases the CPU on success.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum
// byte (8-bit sum of header, data and checksum must be zero).
module program_loader
  import arch_defs_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = LOADER_SYNC_DEFAULT,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           byte_count
);

  loader_state_t state, state_nxt;

  logic                  alive;     // low in reset so rx_ready waits for the first edge
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [8:0]            len_q;     // 1..256
  logic [15:0]           count_q;
  logic                  err_q;
  logic                  xfer;
  logic                  last_write;
  logic                  expired;

  assign xfer       = rx_valid && rx_ready;
  assign last_write = (count_q + 16'd1) == {7'd0, len_q};

  assign rx_ready   = alive && !(state inside {WRITE, DONE, ERROR});
  assign mem_we     = (state == WRITE);
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign cpu_hold   = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_error = err_q;
  assign byte_count = count_q;

  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (xfer),
    .enable  (in_frame(state)),
    .expired (expired)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  sum_ok;

  assign sum_ok = ((sum_q + rx_data) == 8'h00);

  // Running sum of header and data bytes; restarts on each accepted sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (xfer) begin
      if (state == IDLE)                                   sum_q <= '0;
      else if (state inside {ADDR_HI, ADDR_LO, LEN, DATA}) sum_q <= sum_q + rx_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a timeout overrides any in-frame transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && rx_data == SYNC_BYTE) state_nxt = ADDR_HI;
      ADDR_HI: if (xfer) state_nxt = ADDR_LO;
      ADDR_LO: if (xfer) state_nxt = LEN;
      LEN:     if (xfer) state_nxt = DATA;
      DATA:    if (xfer) state_nxt = WRITE;
      WRITE: begin
        if (last_write) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:   if (xfer) state_nxt = sum_ok ? DONE : ERROR;
`endif
      DONE:    if (load_req) state_nxt = IDLE;
      ERROR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (expired) state_nxt = ERROR;
  end

  // Header latching, write datapath, byte counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: if (xfer && rx_data == SYNC_BYTE) begin
          count_q <= '0;
          err_q   <= 1'b0;
        end
        ADDR_HI: if (xfer) addr_q[15:8] <= rx_data;
        ADDR_LO: if (xfer) addr_q[7:0]  <= rx_data;
        LEN:     if (xfer) len_q <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
        DATA:    if (xfer) data_q <= rx_data;
        WRITE: begin
          addr_q  <= addr_q + 16'd1;
          count_q <= count_q + 16'd1;
        end
        default: ;
      endcase
      if (state_nxt == ERROR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames from the
// requirements plus randomized frames checked against a simple memory-write
// reference built from the frame format.
module tb_program_loader;

  localparam int         TO   = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] wr_q[$];        // observed writes {addr, data}
  logic [7:0]  fdata[256];     // payload of the frame being sent

  program_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && mem_we) wr_q.push_back({mem_addr, mem_data});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one byte (after gap idle cycles); returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    g = 0;
    while (!rx_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (g >= 64) begin
      n_err++;
      $display("FAIL send_byte: rx_ready stayed 0 for %0d cycles, required 1", g);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [7:0] len, input bit gaps,
                            input bit corrupt_cs);
    int n;
    int sum;
    n   = (len == 8'h00) ? 256 : int'(len);
    sum = int'(a[15:8]) + int'(a[7:0]) + int'(len);
    send_byte(SYNC,    gaps ? $urandom_range(0, 2) : 0);
    send_byte(a[15:8], gaps ? $urandom_range(0, 2) : 0);
    send_byte(a[7:0],  gaps ? $urandom_range(0, 2) : 0);
    send_byte(len,     gaps ? $urandom_range(0, 2) : 0);
    for (int i = 0; i < n; i++) begin
      sum += int'(fdata[i]);
      send_byte(fdata[i], gaps ? $urandom_range(0, 2) : 0);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(corrupt_cs ? 8'h00 : 8'((256 - (sum % 256)) % 256), 0);
`else
    if (corrupt_cs) sum = 0;
`endif
  endtask

  // Expected writes: LEN bytes at start address, incrementing modulo 2^16.
  task automatic check_writes(input string tag, input logic [15:0] a, input int n, input int start);
    int bad;
    logic [23:0] exp;
    n_cmp++;
    if (wr_q.size() - start != n) begin
      n_err++;
      $display("FAIL %s write count: got %0d required %0d", tag, wr_q.size() - start, n);
    end else begin
      bad = -1;
      exp = '0;
      for (int i = 0; i < n; i++) begin
        exp = {16'((int'(a) + i) % 65536), fdata[i]};
        if (wr_q[start + i] !== exp && bad < 0) bad = i;
      end
      n_cmp++;
      if (bad >= 0) begin
        exp = {16'((int'(a) + bad) % 65536), fdata[bad]};
        n_err++;
        $display("FAIL %s write[%0d]: got %h@%h required %h@%h", tag, bad,
                 wr_q[start + bad][7:0], wr_q[start + bad][23:8], exp[7:0], exp[23:8]);
      end
    end
  endtask

  task automatic check_done(input string tag, input logic [15:0] a, input logic [7:0] len,
                            input int start);
    int g;
    int n;
    n = (len == 8'h00) ? 256 : int'(len);
    g = 0;
    while (!load_done && g < 20) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (load_done !== 1'b1) begin n_err++; $display("FAIL %s load_done: got %b required 1", tag, load_done); end
    n_cmp++;
    if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL %s cpu_hold: got %b required 0", tag, cpu_hold); end
    n_cmp++;
    if (load_error !== 1'b0) begin n_err++; $display("FAIL %s load_error: got %b required 0", tag, load_error); end
    n_cmp++;
    if (byte_count !== 16'(n)) begin n_err++; $display("FAIL %s byte_count: got %0d required %0d", tag, byte_count, n); end
    n_cmp++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL %s rx_ready in done: got %b required 0", tag, rx_ready); end
    check_writes(tag, a, n, start);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({rx_ready, cpu_hold, mem_we, load_done, load_error} !== 5'b01000) begin
      n_err++;
      $display("FAIL %s flags rdy/hold/we/done/err: got %b required 01000", tag,
               {rx_ready, cpu_hold, mem_we, load_done, load_error});
    end
    n_cmp++;
    if ({mem_addr, mem_data, byte_count} !== 40'h0) begin
      n_err++;
      $display("FAIL %s addr/data/count: got %h/%h/%h required 0", tag, mem_addr, mem_data, byte_count);
    end
  endtask

  task automatic test_reset();
    idle(2);
    check_reset_values("reset");
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_release rx_ready before edge: got %b required 0", rx_ready); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_release rx_ready after edge: got %b required 1", rx_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    int start;
    start = wr_q.size();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33;
    send_frame(16'hF000, 8'd3, 1'b0, 1'b0);
    check_done("basic", 16'hF000, 8'd3, start);
  endtask

  // load_req and an offered byte in the same DONE cycle: load_req wins.
  task automatic test_load_req_priority();
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = SYNC;
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    n_cmp++;
    if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL load_req cpu_hold: got %b required 1", cpu_hold); end
    n_cmp++;
    if (load_done !== 1'b0) begin n_err++; $display("FAIL load_req load_done: got %b required 0", load_done); end
    n_cmp++;
    if (byte_count !== 16'd3) begin n_err++; $display("FAIL load_req byte_not_taken count: got %0d required 3", byte_count); end
    n_cmp++;
    if (rx_ready !== 1'b1) begin n_err++; $display("FAIL load_req rx_ready idle: got %b required 1", rx_ready); end
  endtask

  task automatic test_wrap();
    int start;
    start = wr_q.size();
    fdata[0] = 8'hAA; fdata[1] = 8'hBB;
    send_frame(16'hFFFF, 8'd2, 1'b0, 1'b0);
    check_done("wrap", 16'hFFFF, 8'd2, start);
    pulse_load_req();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum_error();
    int start;
    start = wr_q.size();
    fdata[0] = 8'h55;
    send_frame(16'h0000, 8'd1, 1'b0, 1'b1);
    n_cmp++;
    if ({load_error, cpu_hold, rx_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL cs_error err/hold/rdy: got %b required 110", {load_error, cpu_hold, rx_ready});
    end
    @(negedge clk);
    n_cmp++;
    if ({load_error, rx_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL cs_error idle err/rdy: got %b required 11", {load_error, rx_ready});
    end
    check_writes("cs_error", 16'h0000, 1, start);
  endtask
`endif

  task automatic test_timeout();
    int start;
    start = wr_q.size();
    send_byte(SYNC, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    idle(TO - 1);
    n_cmp++;
    if ({load_error, rx_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout early err/rdy: got %b required 01", {load_error, rx_ready});
    end
    idle(1);
    n_cmp++;
    if ({load_error, cpu_hold, rx_ready} !== 3'b110) begin
      n_err++;
      $display("FAIL timeout err/hold/rdy: got %b required 110", {load_error, cpu_hold, rx_ready});
    end
    idle(1);
    n_cmp++;
    if ({load_error, rx_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL timeout idle err/rdy: got %b required 11", {load_error, rx_ready});
    end
    n_cmp++;
    if (wr_q.size() != start) begin n_err++; $display("FAIL timeout stray writes: got %0d required 0", wr_q.size() - start); end
    start = wr_q.size();
    fdata[0] = 8'h01; fdata[1] = 8'h02; fdata[2] = 8'h03; fdata[3] = 8'h04;
    send_byte(SYNC, 0);
    n_cmp++;
    if (load_error !== 1'b0) begin n_err++; $display("FAIL timeout sync clears err: got %b required 0", load_error); end
    send_byte(8'h40, 0);
    send_byte(8'h10, 0);
    send_byte(8'h04, 0);
    for (int i = 0; i < 4; i++) send_byte(fdata[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'((256 - ((8'h40 + 8'h10 + 4 + 10) % 256)) % 256), 0);
`endif
    check_done("timeout_recover", 16'h4010, 8'd4, start);
    pulse_load_req();
  endtask

  task automatic test_random();
    int start;
    logic [15:0] a;
    logic [7:0]  len;
    logic [7:0]  junk;
    for (int f = 0; f < 7; f++) begin
      a   = 16'($urandom);
      len = (f == 6) ? 8'h00 : 8'($urandom_range(1, 12));
      for (int i = 0; i < 256; i++) fdata[i] = 8'($urandom);
      start = wr_q.size();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h5A;
        send_byte(junk, $urandom_range(0, 1));
      end
      send_frame(a, len, 1'b1, 1'b0);
      check_done("random", a, len, start);
      idle($urandom_range(0, 3));
      pulse_load_req();
    end
  endtask

  task automatic test_reset_mid_data();
    int start;
    send_byte(SYNC, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h05, 0);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    n_cmp++;
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL mid_reset precondition mem_we: got %b required 1", mem_we); end
    #2 reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = wr_q.size();
    fdata[0] = 8'h9E;
    send_frame(16'h2000, 8'd1, 1'b0, 1'b0);
    check_done("after_reset", 16'h2000, 8'd1, start);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_load_req_priority();
    test_wrap();
`ifdef LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    test_timeout();
    test_random();
    test_reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
